// File: rtl/spi_mem_bridge_pkg.sv
// Shared definitions for the SPI flash memory bridge: state encoding,
// flash window defaults and the word returned on a timed-out access.
package spi_bridge_pkg;

    localparam logic [31:0] FLASH_BASE_DEF     = 32'h2000_0000;
    localparam int          FLASH_AW_DEF       = 22;
    localparam int          TIMEOUT_CYCLES_DEF = 20000;
    localparam logic [31:0] ERR_WORD           = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_LOW = 3'd2,
        ST_WAIT_HI  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

endpackage

// File: rtl/spi_mem_bridge_if.sv
// Bus bundles for the bridge: the CPU request/ack port and the
// start/ready port towards the SPI flash controller.
interface spi_bridge_cpu_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                    input  cpu_ack, cpu_err, cpu_rdata);
    modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                    output cpu_ack, cpu_err, cpu_rdata);
endinterface

interface spi_bridge_spi_if;
    logic        spi_start;
    logic        spi_we;
    logic [31:0] spi_addr;
    logic [31:0] spi_wdata;
    logic [31:0] spi_rd;
    logic        spi_ready;

    modport master (output spi_start, spi_we, spi_addr, spi_wdata,
                    input  spi_rd, spi_ready);
    modport slave  (input  spi_start, spi_we, spi_addr, spi_wdata,
                    output spi_rd, spi_ready);
endinterface

// File: rtl/spi_mem_bridge_timer.sv
// Loadable down-counter used as a transaction watchdog. Expired is high
// whenever the count sits at zero; the count never wraps below zero.
module spi_bridge_timer #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Count register: clear beats load, load beats the enabled count-down.
    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/spi_mem_bridge.sv
// Memory-stage front end for the SPI flash controller: decodes the flash
// window, serves repeated reads from a one-entry buffer and otherwise runs
// one SPI transaction per request, guarded by a watchdog timeout.
module spi_mem_bridge
    import spi_bridge_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE     = FLASH_BASE_DEF,
    parameter int          FLASH_AW       = FLASH_AW_DEF,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             CLK,
    input  logic             reset,
    spi_bridge_cpu_if.slave  cpu,
    spi_bridge_spi_if.master spi,
    output logic             busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_buf_valid;
    logic [31:0] r_buf_tag;
    logic [31:0] r_buf_data;

    logic        r_spi_we;
    logic [31:0] r_spi_addr;
    logic [31:0] r_spi_wdata;
    logic [31:0] r_op_addr;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_in_win;
    logic        w_misaligned;
    logic        w_reject;
    logic        w_hit;
    logic        w_accept;
    logic        w_done;
    logic        w_timeout;
    logic        w_expired;
    logic [23:0] w_offset;

    logic        w_ack;
    logic        w_start;
    logic        w_busy;
    logic        w_tmr_load;
    logic        w_tmr_en;

    assign w_in_win     = (cpu.cpu_addr[31:FLASH_AW] == FLASH_BASE[31:FLASH_AW]);
    assign w_misaligned = (cpu.cpu_addr[1:0] != 2'b00);
    assign w_reject     = !w_in_win || w_misaligned;
    assign w_hit        = !cpu.cpu_we && r_buf_valid && (r_buf_tag == cpu.cpu_addr);
    assign w_offset     = 24'(cpu.cpu_addr[FLASH_AW-1:0]);
    assign w_accept     = (r_state == ST_IDLE) && cpu.cpu_req;
    // Completion takes priority over a watchdog expiry in the same cycle.
    assign w_done       = (r_state == ST_WAIT_HI) && spi.spi_ready;
    assign w_timeout    = ((r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HI))
                          && w_expired && !w_done;

    // Watchdog: loaded on issue, counts down while waiting on the controller.
    spi_bridge_timer #(.W(TMR_W)) u_timer (
        .CLK        (CLK),
        .reset      (reset),
        .i_clear    (w_ack),
        .i_load     (w_tmr_load),
        .i_load_val (TMR_W'(TIMEOUT_CYCLES - 1)),
        .i_en       (w_tmr_en),
        .o_expired  (w_expired)
    );

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; WAIT_LOW waits out a stale ready from the last transfer.
    // NOTE: default assignment first, so no path leaves the signal unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu.cpu_req) begin
                    w_next_state = (w_reject || w_hit) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE:    w_next_state = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                if (w_expired) begin
                    w_next_state = ST_RESP;
                end else if (!spi.spi_ready) begin
                    w_next_state = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (spi.spi_ready || w_expired) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded strobes: start pulse, ack pulse, watchdog control, busy.
    always_comb begin
        w_ack      = 1'b0;
        w_start    = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        w_busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_ISSUE: begin
                w_start    = 1'b1;
                w_tmr_load = 1'b1;
            end
            ST_WAIT_LOW, ST_WAIT_HI: w_tmr_en = 1'b1;
            ST_RESP:                 w_ack    = 1'b1;
            default: ;
        endcase
    end

    // Request latching on acceptance and response capture on completion or timeout.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_spi_we    <= 1'b0;
            r_spi_addr  <= '0;
            r_spi_wdata <= '0;
            r_op_addr   <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (w_accept) begin
                if (w_reject) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end else if (w_hit) begin
                    r_err   <= 1'b0;
                    r_rdata <= r_buf_data;
                end else begin
                    r_spi_we    <= cpu.cpu_we;
                    r_spi_addr  <= {8'h00, w_offset};
                    r_spi_wdata <= cpu.cpu_wdata;
                    r_op_addr   <= cpu.cpu_addr;
                end
            end
            if (w_done) begin
                r_err   <= 1'b0;
                r_rdata <= r_spi_we ? '0 : spi.spi_rd;
            end else if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= ERR_WORD;
            end
        end
    end

    // Single-entry read buffer: filled by successful reads, written through by matching writes.
    // NOTE: only the valid bit matters functionally; tag and data are reset with it since the entry is tiny.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if (w_done) begin
            if (!r_spi_we) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= r_op_addr;
                r_buf_data  <= spi.spi_rd;
            end else if (r_buf_valid && (r_buf_tag == r_op_addr)) begin
                r_buf_data  <= r_spi_wdata;
            end
        end
    end

    assign cpu.cpu_ack   = w_ack;
    assign cpu.cpu_err   = r_err;
    assign cpu.cpu_rdata = r_rdata;
    assign spi.spi_start = w_start;
    assign spi.spi_we    = r_spi_we;
    assign spi.spi_addr  = r_spi_addr;
    assign spi.spi_wdata = r_spi_wdata;
    assign busy          = w_busy;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Scoreboard bench for spi_mem_bridge: stimulus predicts each response from a
// behavioural model of the flash window and read buffer, a monitor checks acks.
module tb_spi_mem_bridge;
    import spi_bridge_pkg::*;

    localparam int          TMO       = 250;
    localparam logic [31:0] BASE      = 32'h2000_0000;
    localparam logic [31:0] WIN_BYTES = 32'h0040_0000;
    localparam int          ACK_LIMIT = TMO + 400;

    typedef enum int {M_NORMAL, M_NEVER, M_STALE} mode_t;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          n_start;
        logic        we;
        logic [31:0] saddr;
        logic [31:0] wdata;
        int          lat;
        int          t_req;
    } exp_t;

    logic CLK   = 1'b0;
    logic reset = 1'b1;
    logic busy;

    spi_bridge_cpu_if cpu ();
    spi_bridge_spi_if spi ();

    spi_mem_bridge #(.TIMEOUT_CYCLES(TMO)) u_dut (
        .CLK   (CLK),
        .reset (reset),
        .cpu   (cpu),
        .spi   (spi),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Flash contents seen by the controller model, keyed by window offset.
    logic [31:0] flash [logic [31:0]];

    function automatic logic [31:0] flash_rd(input logic [31:0] off);
        return flash.exists(off) ? flash[off] : ((off * 32'h9E37_79B9) ^ 32'h0F0F_0000);
    endfunction

    // Reference read buffer.
    logic        ref_valid = 1'b0;
    logic [31:0] ref_tag   = '0;
    logic [31:0] ref_data  = '0;

    exp_t  sb [$];
    mode_t mdl_mode = M_NORMAL;
    int    mdl_lat  = 4;
    logic  mdl_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"},      32'(busy),          32'h0);
        check({pfx, "_ack"},       32'(cpu.cpu_ack),   32'h0);
        check({pfx, "_err"},       32'(cpu.cpu_err),   32'h0);
        check({pfx, "_rdata"},     cpu.cpu_rdata,      32'h0);
        check({pfx, "_spi_start"}, 32'(spi.spi_start), 32'h0);
        check({pfx, "_spi_we"},    32'(spi.spi_we),    32'h0);
        check({pfx, "_spi_addr"},  spi.spi_addr,       32'h0);
        check({pfx, "_spi_wdata"}, spi.spi_wdata,      32'h0);
    endtask

    // SPI controller model: reacts to start, drives ready/rd per the selected mode.
    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic        w;
        spi.spi_ready = 1'b0;
        spi.spi_rd    = '0;
        forever begin
            @(negedge CLK);
            if (!reset && spi.spi_start) begin
                mdl_busy = 1'b1;
                a  = spi.spi_addr;
                w  = spi.spi_we;
                wd = spi.spi_wdata;
                case (mdl_mode)
                    M_NORMAL: begin
                        spi.spi_ready = 1'b0;
                        repeat (mdl_lat) @(negedge CLK);
                        if (w) begin
                            flash[a]   = wd;
                            spi.spi_rd = $urandom;
                        end else begin
                            spi.spi_rd = flash_rd(a);
                        end
                        spi.spi_ready = 1'b1;
                    end
                    M_NEVER: spi.spi_ready = 1'b0;
                    default: begin
                        repeat (5) @(negedge CLK);
                        spi.spi_ready = 1'b0;
                        repeat (3) @(negedge CLK);
                        spi.spi_rd    = flash_rd(a);
                        spi.spi_ready = 1'b1;
                    end
                endcase
                mdl_busy = 1'b0;
            end
        end
    end

    // Monitor: counts start pulses and checks every ack against the scoreboard.
    int          start_cnt = 0;
    logic        cap_we    = 1'b0;
    logic [31:0] cap_addr  = '0;
    logic [31:0] cap_wdata = '0;
    always @(negedge CLK) begin
        exp_t e;
        if (reset) begin
            start_cnt = 0;
        end else begin
            if (spi.spi_start) begin
                start_cnt++;
                cap_we    = spi.spi_we;
                cap_addr  = spi.spi_addr;
                cap_wdata = spi.spi_wdata;
            end
            if (cpu.cpu_ack) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: ack with nothing outstanding, rdata 0x%08h", cpu.cpu_rdata);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_err"},        32'(cpu.cpu_err), 32'(e.err));
                    check({e.name, "_rdata"},      cpu.cpu_rdata,    e.rdata);
                    check({e.name, "_spi_starts"}, start_cnt,        e.n_start);
                    if (e.n_start > 0) begin
                        check({e.name, "_spi_we"},    32'(cap_we), 32'(e.we));
                        check({e.name, "_spi_addr"},  cap_addr,    e.saddr);
                        check({e.name, "_spi_wdata"}, cap_wdata,   e.wdata);
                    end
                    if (e.lat >= 0) check({e.name, "_latency"}, cyc - e.t_req, e.lat);
                end
                start_cnt = 0;
            end
        end
    end

    // Predict the response, push it, then run the req/ack handshake.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input mode_t mode, input int lat);
        exp_t        e;
        logic        in_win;
        logic [31:0] off;
        bit          got;
        in_win    = (addr >= BASE) && (addr < BASE + WIN_BYTES);
        off       = addr - BASE;
        e.name    = name;
        e.we      = we;
        e.wdata   = wdata;
        e.saddr   = off;
        e.n_start = 1;
        e.lat     = -1;
        if (!in_win || (addr % 4 != 0)) begin
            e.err = 1'b1; e.rdata = '0; e.n_start = 0; e.lat = 1;
        end else if (!we && ref_valid && ref_tag == addr) begin
            e.err = 1'b0; e.rdata = ref_data; e.n_start = 0; e.lat = 1;
        end else if (mode == M_NEVER) begin
            e.err = 1'b1; e.rdata = ERR_WORD; e.lat = TMO + 2;
        end else if (we) begin
            e.err = 1'b0; e.rdata = '0;
            if (ref_valid && ref_tag == addr) ref_data = wdata;
        end else begin
            e.err     = 1'b0;
            e.rdata   = flash_rd(off);
            ref_valid = 1'b1;
            ref_tag   = addr;
            ref_data  = e.rdata;
        end
        mdl_mode = mode;
        mdl_lat  = lat;
        @(negedge CLK);
        e.t_req = cyc;
        sb.push_back(e);
        cpu.cpu_req   = 1'b1;
        cpu.cpu_we    = we;
        cpu.cpu_addr  = addr;
        cpu.cpu_wdata = wdata;
        got = 1'b0;
        for (int i = 0; i < ACK_LIMIT && !got; i++) begin
            @(negedge CLK);
            if (cpu.cpu_ack) got = 1'b1;
        end
        cpu.cpu_req = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ack_wait: no ack within %0d cycles", name, ACK_LIMIT);
            sb.delete();
        end
    endtask

    initial begin
        cpu.cpu_req   = 1'b0;
        cpu.cpu_we    = 1'b0;
        cpu.cpu_addr  = '0;
        cpu.cpu_wdata = '0;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        reset = 1'b0;

        flash[32'h0000_0104] = 32'h1234_5678;
        do_req("rd_miss",       1'b0, 32'h2000_0104, $urandom,      M_NORMAL, 200);
        do_req("rd_hit",        1'b0, 32'h2000_0104, $urandom,      M_NORMAL, 4);
        do_req("wr_through",    1'b1, 32'h2000_0104, 32'hCAFE_F00D, M_NORMAL, 6);
        do_req("rd_after_wr",   1'b0, 32'h2000_0104, 32'h0,         M_NORMAL, 4);
        do_req("out_of_window", 1'b0, 32'h1000_0000, 32'h0,         M_NORMAL, 4);
        do_req("misaligned",    1'b0, 32'h2000_0102, 32'h0,         M_NORMAL, 4);
        do_req("wr_misaligned", 1'b1, 32'h2000_0105, 32'h1111_2222, M_NORMAL, 4);
        do_req("win_past_end",  1'b0, 32'h2040_0000, 32'h0,         M_NORMAL, 4);
        do_req("win_last_word", 1'b0, 32'h203F_FFFC, 32'h0,         M_NORMAL, 3);
        do_req("timeout",       1'b0, 32'h2000_0200, 32'h0,         M_NEVER,  0);
        do_req("rd_after_tmo",  1'b0, 32'h2000_0200, 32'h0,         M_NORMAL, 5);
        flash[32'h0000_0300] = 32'hA5A5_A5A5;
        do_req("stale_ready",   1'b0, 32'h2000_0300, 32'h0,         M_STALE,  0);

        // Abort a miss while it waits for the controller.
        mdl_mode = M_NORMAL;
        mdl_lat  = 200;
        @(negedge CLK);
        cpu.cpu_req  = 1'b1;
        cpu.cpu_we   = 1'b0;
        cpu.cpu_addr = 32'h2000_0400;
        repeat (15) @(negedge CLK);
        check("abort_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check_zero("abort");
        cpu.cpu_req = 1'b0;
        for (int i = 0; i < 400 && mdl_busy; i++) @(negedge CLK);
        @(negedge CLK);
        reset     = 1'b0;
        ref_valid = 1'b0;
        do_req("rd_after_reset", 1'b0, 32'h2000_0300, 32'h0, M_NORMAL, 4);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = 32'h1FFF_FFFC;
                1:       a = 32'h2040_0010;
                2:       a = 32'h2000_0012;
                3, 4:    a = 32'h2000_0010;
                5, 6:    a = 32'h2000_0014;
                7:       a = 32'h2000_0800;
                default: a = 32'h203F_FFFC;
            endcase
            do_req($sformatf("rand%0d", n), ($urandom_range(0, 2) == 0), a, $urandom,
                   M_NORMAL, int'($urandom_range(2, 20)));
        end

        repeat (5) @(negedge CLK);
        check("sb_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
